// File: rtl/ma_window_sched_if.sv
// Requester-side handshake bundle for ma_window_sched: per-requester
// valid/data, the one-hot grant coming back, and the flush request.
interface ma_window_sched_if #(
  parameter int NUM_REQ = 3,
  parameter int DW      = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  flush;

  // Sample sources and the flush requester
  modport master (output req_valid, req_data, flush, input req_ready);
  // The scheduler
  modport slave  (input req_valid, req_data, flush, output req_ready);
endinterface

// File: rtl/ma_window_sched.sv
// ma_window_sched: round-robin sample scheduler for the moving-average
// datapath. Grants one requester at a time, issues a shift pulse per
// accepted sample, tracks window fill and raises out_enable once the
// window holds WINDOW_SIZE samples. A flush (sticky) clears the window.
// Optional feature: define MA_SCHED_AUTOFLUSH_EN to build an idle counter
// that raises a flush after IDLE_TIMEOUT quiet cycles with a non-empty window.
// Reset rst_n is asynchronous and active-high (1 = in reset).
module ma_window_sched #(
  parameter int NUM_REQ      = 3,
  parameter int WINDOW_SIZE  = 4,
  parameter int DW           = 2,
  parameter int IDLE_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  ma_window_sched_if.slave    bus,
  output logic                ma_shift,
  output logic [DW-1:0]       ma_data,
  output logic [1:0]          ma_src,
  output logic                ma_clear,
  output logic [3:0]          fill_count,
  output logic                window_full,
  output logic                out_enable,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, GRANT, ISSUE, CLEAR} state_t;

  localparam logic [3:0] FULL_CNT = 4'(WINDOW_SIZE);

  state_t     state;
  logic [1:0] last_grant;
  logic [1:0] grant_idx;
  logic [1:0] win_idx;
  logic       pending;
  logic       auto_flush;
  logic       flush_evt;
  logic [3:0] fill_next;

  assign flush_evt = bus.flush | auto_flush;

  // Round-robin winner: first valid requester after last_grant, wrapping.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    // NOTE: every variable gets a value before any branch so no latch is inferred.
    win_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = 2'((int'(last_grant) + k) % NUM_REQ);
      if (!found && bus.req_valid[idx]) begin
        win_idx = idx;
        found   = 1'b1;
      end
    end
  end

  // Next fill level: cleared by CLEAR, bumped by ISSUE, saturating when full.
  always_comb begin
    fill_next = fill_count;
    if (state == CLEAR)
      fill_next = '0;
    else if (state == ISSUE && fill_count != FULL_CNT)
      fill_next = fill_count + 4'd1;
  end

  // Scheduler FSM with all outputs registered alongside the state.
  // NOTE: asynchronous reset in the sensitivity list, and <= for every
  // state element so all registers update together on the edge.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state         <= IDLE;
      last_grant    <= 2'(NUM_REQ - 1);
      grant_idx     <= '0;
      pending       <= 1'b0;
      bus.req_ready <= '0;
      ma_shift      <= 1'b0;
      ma_data       <= '0;
      ma_src        <= '0;
      ma_clear      <= 1'b0;
      fill_count    <= '0;
      window_full   <= 1'b0;
      out_enable    <= 1'b0;
      busy          <= 1'b0;
    end else begin
      bus.req_ready <= '0;
      ma_shift      <= 1'b0;
      ma_clear      <= 1'b0;
      fill_count    <= fill_next;
      window_full   <= (fill_next == FULL_CNT);
      out_enable    <= (fill_next == FULL_CNT);
      if (flush_evt)
        pending <= 1'b1;

      case (state)
        IDLE: begin
          if (pending || flush_evt) begin
            state    <= CLEAR;
            ma_clear <= 1'b1;
            busy     <= 1'b1;
          end else if (|bus.req_valid) begin
            grant_idx     <= win_idx;
            bus.req_ready <= NUM_REQ'(1) << win_idx;
            state         <= GRANT;
            busy          <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        GRANT: begin
          if (bus.req_valid[grant_idx]) begin
            ma_data    <= bus.req_data[grant_idx*DW +: DW];
            ma_src     <= grant_idx;
            last_grant <= grant_idx;
            ma_shift   <= 1'b1;
            state      <= ISSUE;
            busy       <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        ISSUE: begin
          // A flush that arrived while this sample was in flight clears right after it.
          if (pending || flush_evt) begin
            state    <= CLEAR;
            ma_clear <= 1'b1;
            busy     <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        CLEAR: begin
          // NOTE: the last non-blocking assignment in the block wins, so this
          // overrides the flush-sets-pending assignment above.
          pending <= 1'b0;
          state   <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MA_SCHED_AUTOFLUSH_EN
  logic [7:0] idle_cnt;
  logic       xfer;

  assign xfer       = (state == GRANT) && bus.req_valid[grant_idx];
  assign auto_flush = (idle_cnt == 8'(IDLE_TIMEOUT));

  // Idle counter: counts quiet cycles with samples in the window, holds at the limit.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)
      idle_cnt <= '0;
    else if (xfer || state == CLEAR)
      idle_cnt <= '0;
    else if (fill_count != 4'd0 && !auto_flush)
      idle_cnt <= idle_cnt + 8'd1;
  end
`else
  logic [7:0] unused_timeout;

  assign auto_flush     = 1'b0;
  assign unused_timeout = 8'(IDLE_TIMEOUT);
`endif

endmodule

// File: tb/tb_ma_window_sched.sv
// Directed testbench for ma_window_sched with hand-computed expectations.
// Outputs are sampled 1 ns after the rising edge; inputs change right after.
module tb_ma_window_sched;
  localparam int NR = 3;
  localparam int WS = 4;
  localparam int DW = 2;
  localparam int TO = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ma_shift;
  logic [DW-1:0] ma_data;
  logic [1:0]    ma_src;
  logic          ma_clear;
  logic [3:0]    fill_count;
  logic          window_full;
  logic          out_enable;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  ma_window_sched_if #(.NUM_REQ(NR), .DW(DW)) bus ();

  ma_window_sched #(
    .NUM_REQ(NR), .WINDOW_SIZE(WS), .DW(DW), .IDLE_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .ma_shift(ma_shift), .ma_data(ma_data), .ma_src(ma_src),
    .ma_clear(ma_clear), .fill_count(fill_count), .window_full(window_full),
    .out_enable(out_enable), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a grant, then check the grant and the following shift.
  task automatic exp_sample(input string tag, input int src, input logic [1:0] data);
    int n = 0;
    while (bus.req_ready == '0 && n < 8) begin
      step();
      n++;
    end
    check({tag, "_ready"}, 32'(bus.req_ready), 32'(1 << src));
    step();
    check({tag, "_shift"}, 32'(ma_shift), 1);
    check({tag, "_src"},   32'(ma_src), 32'(src));
    check({tag, "_data"},  32'(ma_data), 32'(data));
    step();
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.req_ready == '0 && n < 8) begin
      step();
      n++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    repeat (2) step();
    rst_n = 1'b0;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int clr_cnt;
    int d;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.flush     = 1'b0;

    // Reset values
    rst_n = 1'b1;
    repeat (2) step();
    check("rst_ready", 32'(bus.req_ready), 0);
    check("rst_shift", 32'(ma_shift), 0);
    check("rst_fill",  32'(fill_count), 0);
    check("rst_oe",    32'(out_enable), 0);
    check("rst_busy",  32'(busy), 0);
    rst_n = 1'b0;

    // Single sample from requester 0, exact latency
    bus.req_valid = 3'b001;
    bus.req_data  = 6'b000010;
    step();
    check("t1_ready", 32'(bus.req_ready), 32'b001);
    step();
    check("t1_shift", 32'(ma_shift), 1);
    check("t1_data",  32'(ma_data), 32'b10);
    check("t1_src",   32'(ma_src), 0);
    check("t1_ready_low", 32'(bus.req_ready), 0);
    bus.req_valid = '0;
    step();
    check("t1_fill", 32'(fill_count), 1);
    check("t1_shift_low", 32'(ma_shift), 0);

    // Three requesters continuously valid: grants 0,1,2,0,1
    do_reset();
    bus.req_valid = 3'b111;
    bus.req_data  = {2'b11, 2'b10, 2'b01};
    exp_sample("t2_g0", 0, 2'b01);
    check("t2_fill1", 32'(fill_count), 1);
    exp_sample("t2_g1", 1, 2'b10);
    exp_sample("t2_g2", 2, 2'b11);
    check("t2_fill3", 32'(fill_count), 3);
    check("t2_oe3",   32'(out_enable), 0);
    exp_sample("t2_g3", 0, 2'b01);
    check("t2_fill4", 32'(fill_count), 4);
    check("t2_full4", 32'(window_full), 1);
    check("t2_oe4",   32'(out_enable), 1);
    exp_sample("t2_g4", 1, 2'b10);
    bus.req_valid = '0;
    check("t2_fill_sat", 32'(fill_count), 4);
    check("t2_oe_sat",   32'(out_enable), 1);

    // Flush during GRANT: sample still shifted, then cleared
    bus.req_valid = 3'b001;
    bus.req_data  = 6'b000010;
    wait_ready();
    check("t3_ready", 32'(bus.req_ready), 32'b001);
    bus.flush = 1'b1;
    step();
    bus.flush     = 1'b0;
    bus.req_valid = '0;
    check("t3_shift", 32'(ma_shift), 1);
    check("t3_data",  32'(ma_data), 32'b10);
    step();
    check("t3_clear", 32'(ma_clear), 1);
    step();
    check("t3_fill0", 32'(fill_count), 0);
    check("t3_oe0",   32'(out_enable), 0);
    check("t3_full0", 32'(window_full), 0);
    check("t3_clear_low", 32'(ma_clear), 0);

    // Requester 1 drops valid before its grant edge: no transfer
    bus.req_valid = 3'b010;
    wait_ready();
    check("t4_ready", 32'(bus.req_ready), 32'b010);
    bus.req_valid = '0;
    step();
    check("t4_no_shift", 32'(ma_shift), 0);
    check("t4_idle", 32'(busy), 0);
    step();
    check("t4_fill", 32'(fill_count), 0);
    bus.req_valid = 3'b111;
    bus.req_data  = {2'b11, 2'b10, 2'b01};
    exp_sample("t4_rr", 1, 2'b10);
    bus.req_valid = '0;
    check("t4_fill1", 32'(fill_count), 1);

    // Reset during ISSUE aborts immediately; requester 0 wins after release
    bus.req_valid = 3'b111;
    wait_ready();
    check("t5_ready", 32'(bus.req_ready), 32'b100);
    step();
    check("t5_shift", 32'(ma_shift), 1);
    rst_n = 1'b1;
    #1;
    check("t5_rst_shift", 32'(ma_shift), 0);
    check("t5_rst_ready", 32'(bus.req_ready), 0);
    check("t5_rst_src",   32'(ma_src), 0);
    check("t5_rst_data",  32'(ma_data), 0);
    check("t5_rst_fill",  32'(fill_count), 0);
    check("t5_rst_busy",  32'(busy), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_sample("t5_first", 0, 2'b01);
    bus.req_valid = '0;

    // Two samples then silence
    do_reset();
    bus.req_valid = 3'b001;
    bus.req_data  = 6'b000001;
    exp_sample("t6_s0", 0, 2'b01);
    exp_sample("t6_s1", 0, 2'b01);
    bus.req_valid = '0;
    check("t6_fill2", 32'(fill_count), 2);
`ifdef MA_SCHED_AUTOFLUSH_EN
    d = 1;
    while (!ma_clear && d < 40) begin
      step();
      d++;
    end
    check("af_delay_ok", 32'(d >= 10 && d <= 12), 1);
    step();
    check("af_fill0", 32'(fill_count), 0);
`else
    clr_cnt = 0;
    d = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (ma_clear) clr_cnt++;
      if (fill_count != 4'd2) d++;
    end
    check("t6_hold_fill", 32'(fill_count), 2);
    check("t6_hold_dev",  32'(d), 0);
    check("t6_no_clear",  32'(clr_cnt), 0);
`endif

    // Flush seen in IDLE: clear next cycle, window empty the cycle after
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("t7_clear", 32'(ma_clear), 1);
    check("t7_busy",  32'(busy), 1);
    step();
    check("t7_fill0",  32'(fill_count), 0);
    check("t7_oe0",    32'(out_enable), 0);
    check("t7_clr_lo", 32'(ma_clear), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ma_window_sched.md
# ma_window_sched

Sequencing and arbitration controller for the 2-bit moving-average datapath. It accepts samples from up to NUM_REQ requesters over valid/ready handshakes, grants them round-robin, and issues one shift pulse per accepted sample. It tracks window fill and drives the datapath's output enable only once the window holds WINDOW_SIZE samples. It sits between the sensor-side sources and the averager on the `ui_in`/`uo_out` side of the top level.

## Interface
- NUM_REQ, 3: number of requesters (2..4).
- WINDOW_SIZE, 4: averager window depth (1..15).
- DW, 2: sample width in bits.
- IDLE_TIMEOUT, 255: auto-flush idle limit in cycles (1..255). Used only with MA_SCHED_AUTOFLUSH_EN.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-high reset; 1 = reset asserted.
- req_valid  in  NUM_REQ  per-requester sample valid.
- req_data  in  NUM_REQ*DW  packed samples; requester i occupies bits [i*DW +: DW].
- req_ready  out  NUM_REQ  one-hot grant; a sample transfers when req_valid[i] & req_ready[i].
- flush  in  1  single-cycle request to clear the window.
- ma_shift  out  1  one-cycle pulse that pushes ma_data into the averager.
- ma_data  out  DW  sample being shifted; valid while ma_shift = 1.
- ma_src  out  2  index of the requester whose sample is on ma_data.
- ma_clear  out  1  one-cycle pulse that zeroes the averager window and sums.
- fill_count  out  4  number of samples in the window; saturates at WINDOW_SIZE.
- window_full  out  1  fill_count == WINDOW_SIZE.
- out_enable  out  1  averager output enable (drives p = 2'b11 when 1).
- busy  out  1  FSM state is not IDLE.

## Operation
- FSM states and transitions:
  - IDLE: if a flush is pending, go to CLEAR. Otherwise, if any req_valid is set, latch the round-robin winner and go to GRANT.
  - GRANT: req_ready[winner] = 1 for exactly this cycle. Capture req_data of the winner and go to ISSUE. If the winner's req_valid has dropped, no transfer occurs and the FSM returns to IDLE.
  - ISSUE: ma_shift = 1, ma_data and ma_src are registered. fill_count increments, saturating at WINDOW_SIZE. Go to IDLE.
  - CLEAR: ma_clear = 1, fill_count goes to 0, the pending flag is cleared. Go to IDLE.
- Round-robin arbitration:
  - Search starts at last_grant+1 mod NUM_REQ.
  - last_grant updates only on a completed transfer.
  - Reset value of last_grant is NUM_REQ-1, so requester 0 wins first.
- Flush handling:
  - A flush pulse in any state sets a sticky pending flag.
  - A sample already granted still completes ISSUE. CLEAR follows immediately, so that sample is discarded.
  - Flush has priority over new grants in IDLE.
- Output enable:
  - out_enable and window_full are registered from fill_count.
  - Shifts continue while the window is full; fill_count holds at WINDOW_SIZE.
- Reset values: req_ready=0, ma_shift=0, ma_data=0, ma_src=0, ma_clear=0, fill_count=0, window_full=0, out_enable=0, busy=0, state=IDLE, pending flag=0.
- Reset asserted mid-transfer aborts immediately. No shift or clear pulse is emitted.

## Timing
- req_valid seen in IDLE at cycle n:
  - req_ready is high at n+1.
  - ma_shift is high at n+2.
  - fill_count reflects the sample at n+3.
- Maximum throughput is one sample per 3 cycles.
- Flush seen at cycle n with FSM in IDLE: ma_clear at n+1, fill_count=0 and out_enable=0 at n+2.
- window_full and out_enable rise the cycle after the WINDOW_SIZE-th ma_shift.
- Requesters must hold req_valid and req_data stable until the ready cycle.
- req_ready is never high for more than one cycle per grant.

## Configuration
- MA_SCHED_AUTOFLUSH_EN defined:
  - An 8-bit idle counter increments every cycle in which fill_count > 0 and no transfer completes.
  - It resets to 0 on any transfer or CLEAR.
  - When it reaches IDLE_TIMEOUT, the pending flush flag is set, exactly as an external flush would.
- MA_SCHED_AUTOFLUSH_EN undefined: no counter is built, IDLE_TIMEOUT is ignored, and the window holds indefinitely.

## Test plan
- Reset then single sample: req_valid=3'b001 with data 2'b10 held. Expect req_ready=001 at cycle 1, ma_shift with ma_data=10 and ma_src=0 at cycle 2, fill_count=1 at cycle 3.
- All three requesters valid continuously: grants cycle 0,1,2,0. After 4 shifts, window_full=1 and out_enable=1. fill_count stays 4 after the 5th shift.
- Flush asserted during GRANT: that sample is still shifted. ma_clear follows in the next cycle, then fill_count=0 and out_enable=0.
- Requester drops req_valid before its grant cycle: no ma_shift, fill_count unchanged, last_grant unchanged.
- Reset asserted during ISSUE: all outputs go to 0 immediately. After release, requester 0 is granted first.
- With MA_SCHED_AUTOFLUSH_EN and IDLE_TIMEOUT=10: after 2 samples then silence, ma_clear pulses about 11 cycles after the last transfer. Without the macro, fill_count stays 2 for 1000 cycles.
